// File: rtl/gravsim_pkg.sv
// Shared types for the gravity-sim render path: body field selectors and the
// per-body float record passed between the physics engine and the renderer.
package gravsim_pkg;

    typedef enum logic [1:0] {
        FLD_RAD = 2'd0,
        FLD_X   = 2'd1,
        FLD_Y   = 2'd2,
        FLD_Z   = 2'd3
    } field_e;

    localparam logic [31:0] FLOAT_ZERO = 32'h00000000;

    typedef struct packed {
        logic [31:0] radius;
        logic [31:0] posX;
        logic [31:0] posY;
        logic [31:0] posZ;
    } body_t;

    localparam body_t BODY_ZERO = '{
        radius: FLOAT_ZERO,
        posX:   FLOAT_ZERO,
        posY:   FLOAT_ZERO,
        posZ:   FLOAT_ZERO
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/frame_edge_det.sv
// Rising-edge detector for the VGA frame marker; frame_clk is assumed to be
// synchronous to Clk already, so a single history flop is enough.
module frame_edge_det (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_edge
);

    logic frame_clk_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
        end
    end

    assign frame_edge = frame_clk & ~frame_clk_q;

endmodule

// File: rtl/body_param_bank.sv
// Double-buffered body parameter bank: shadow is loaded by the physics writer and
// swapped into active only at a frame boundary. Optional BODY_PARAM_STALE_CNT_EN
// adds a saturating count of frame boundaries seen without a commit.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | accepting shadow writes, waiting for commit_req
// ST_PENDING | commit requested, writes stalled until the next frame edge
// ST_SWAP    | one cycle: active <= shadow, commit_done pulses
module body_param_bank
    import gravsim_pkg::*;
#(
    parameter int NUM_BODIES = 4,
    parameter int IDX_W      = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_field,
    input  logic [31:0]      wr_data,
    input  logic             commit_req,
    output logic             commit_done,
    output logic             pending,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      radius,
    output logic [31:0]      posX,
    output logic [31:0]      posY,
    output logic [31:0]      posZ,
    output logic [IDX_W-1:0] rd_valid_idx
`ifdef BODY_PARAM_STALE_CNT_EN
    ,
    output logic [15:0]      stale_frames
`endif
);

    localparam logic [IDX_W:0] NUM_BODIES_W = (IDX_W+1)'(NUM_BODIES);

    bank_state_e state;
    body_t       shadow [NUM_BODIES];
    body_t       active [NUM_BODIES];
    body_t       rd_q;
    logic        frame_edge;
    logic        wr_fire;
    logic        wr_in_range;
    logic        rd_in_range;

    frame_edge_det u_frame_edge_det (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_edge (frame_edge)
    );

    assign wr_fire     = wr_valid & wr_ready;
    assign wr_in_range = {1'b0, wr_idx} < NUM_BODIES_W;
    assign rd_in_range = {1'b0, rd_idx} < NUM_BODIES_W;

    // Out-of-range writes still complete the handshake; they just land nowhere.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_BODIES; i++) begin
                shadow[i] <= BODY_ZERO;
            end
        end else if (wr_fire && wr_in_range) begin
            case (field_e'(wr_field))
                FLD_RAD: shadow[wr_idx].radius <= wr_data;
                FLD_X:   shadow[wr_idx].posX   <= wr_data;
                FLD_Y:   shadow[wr_idx].posY   <= wr_data;
                FLD_Z:   shadow[wr_idx].posZ   <= wr_data;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_BODIES; i++) begin
                active[i] <= BODY_ZERO;
            end
        end else if (state == ST_SWAP) begin
            for (int i = 0; i < NUM_BODIES; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    // Only PENDING looks at frame_edge, so an edge coinciding with the
    // commit_req that enters PENDING is naturally ignored.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            wr_ready    <= 1'b1;
            pending     <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (commit_req) begin
                        state    <= ST_PENDING;
                        wr_ready <= 1'b0;
                        pending  <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (frame_edge) begin
                        state       <= ST_SWAP;
                        pending     <= 1'b0;
                        commit_done <= 1'b1;
                    end
                end
                ST_SWAP: begin
                    state       <= ST_IDLE;
                    commit_done <= 1'b0;
                    wr_ready    <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    wr_ready    <= 1'b1;
                    pending     <= 1'b0;
                    commit_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_q         <= BODY_ZERO;
            rd_valid_idx <= '0;
        end else begin
            rd_q         <= rd_in_range ? active[rd_idx] : BODY_ZERO;
            rd_valid_idx <= rd_idx;
        end
    end

    assign radius = rd_q.radius;
    assign posX   = rd_q.posX;
    assign posY   = rd_q.posY;
    assign posZ   = rd_q.posZ;

`ifdef BODY_PARAM_STALE_CNT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stale_frames <= '0;
        end else if (state == ST_SWAP) begin
            stale_frames <= '0;
        end else if (state == ST_IDLE && !commit_req && frame_edge
                     && stale_frames != 16'hFFFF) begin
            stale_frames <= stale_frames + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_body_param_bank.sv
// Bench for body_param_bank: directed scenarios followed by random traffic, all
// checked every cycle against an array-based model of the shadow/active banks.
module tb_body_param_bank;

    localparam int NB = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_idx;
    logic [1:0]  wr_field;
    logic [31:0] wr_data;
    logic        commit_req;
    logic        commit_done;
    logic        pending;
    logic [1:0]  rd_idx;
    logic [31:0] radius;
    logic [31:0] posX;
    logic [31:0] posY;
    logic [31:0] posZ;
    logic [1:0]  rd_valid_idx;
`ifdef BODY_PARAM_STALE_CNT_EN
    logic [15:0] stale_frames;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_shadow [NB][4];
    logic [31:0] m_active [NB][4];
    logic [31:0] m_rd [4];
    logic [1:0]  m_rd_idx;
    logic        m_fc_q;
    int          m_phase;   // 0 open for writes, 1 waiting for boundary, 2 swapping
    int          m_stale;

    body_param_bank #(.NUM_BODIES(NB), .IDX_W(2)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_idx       (wr_idx),
        .wr_field     (wr_field),
        .wr_data      (wr_data),
        .commit_req   (commit_req),
        .commit_done  (commit_done),
        .pending      (pending),
        .rd_idx       (rd_idx),
        .radius       (radius),
        .posX         (posX),
        .posY         (posY),
        .posZ         (posZ),
        .rd_valid_idx (rd_valid_idx)
`ifdef BODY_PARAM_STALE_CNT_EN
        ,
        .stale_frames (stale_frames)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_vec++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            for (int f = 0; f < 4; f++) begin
                m_shadow[b][f] = 32'h0;
                m_active[b][f] = 32'h0;
            end
        end
        for (int f = 0; f < 4; f++) m_rd[f] = 32'h0;
        m_rd_idx = 2'd0;
        m_fc_q   = 1'b0;
        m_phase  = 0;
        m_stale  = 0;
    endtask

    task automatic check_all();
        chk("wr_ready",     32'(wr_ready),     32'(m_phase == 0));
        chk("pending",      32'(pending),      32'(m_phase == 1));
        chk("commit_done",  32'(commit_done),  32'(m_phase == 2));
        chk("radius",       radius,            m_rd[0]);
        chk("posX",         posX,              m_rd[1]);
        chk("posY",         posY,              m_rd[2]);
        chk("posZ",         posZ,              m_rd[3]);
        chk("rd_valid_idx", 32'(rd_valid_idx), 32'(m_rd_idx));
`ifdef BODY_PARAM_STALE_CNT_EN
        chk("stale_frames", 32'(stale_frames), 32'(m_stale));
`endif
    endtask

    // One clock: inputs are stable across the edge, so the model reads them after it.
    task automatic cycle();
        logic fe;
        @(posedge Clk);
        fe = frame_clk & ~m_fc_q;
        for (int k = 0; k < 4; k++) begin
            m_rd[k] = (32'(rd_idx) < NB) ? m_active[rd_idx][k] : 32'h0;
        end
        m_rd_idx = rd_idx;
        if (m_phase == 0 && wr_valid && 32'(wr_idx) < NB) m_shadow[wr_idx][wr_field] = wr_data;
        if (m_phase == 2) m_stale = 0;
        else if (m_phase == 0 && !commit_req && fe && m_stale < 65535) m_stale++;
        case (m_phase)
            0: if (commit_req) m_phase = 1;
            1: if (fe) m_phase = 2;
            default: begin
                for (int b = 0; b < NB; b++)
                    for (int f = 0; f < 4; f++) m_active[b][f] = m_shadow[b][f];
                m_phase = 0;
            end
        endcase
        m_fc_q = frame_clk;
        #1;
        check_all();
    endtask

    // Called at posedge+1: asserts Reset mid-cycle and releases it before the next edge.
    task automatic mid_reset();
        #3;
        Reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        int done_cnt;
        Reset = 1'b1; frame_clk = 1'b0; wr_valid = 1'b0; commit_req = 1'b0;
        wr_idx = 2'd0; wr_field = 2'd0; wr_data = 32'h0; rd_idx = 2'd0;
        model_reset();
        #12;
        check_all();
        Reset = 1'b0;

        for (int i = 0; i < NB; i++) begin
            rd_idx = 2'(i);
            cycle();
        end

        // Load body 1, commit, and hold off the frame boundary for 50 cycles.
        wr_valid = 1'b1; wr_idx = 2'd1; wr_field = 2'd0; wr_data = 32'h40000000;
        cycle();
        wr_field = 2'd1; wr_data = 32'h3F800000;
        cycle();
        wr_valid = 1'b0; commit_req = 1'b1;
        cycle();
        commit_req = 1'b0; rd_idx = 2'd1;
        repeat (50) cycle();
        chk("hold_pending", 32'(pending), 32'd1);
        chk("hold_radius", radius, 32'h0);
        frame_clk = 1'b1;
        cycle();
        chk("swap_done", 32'(commit_done), 32'd1);
        frame_clk = 1'b0;
        cycle();
        cycle();
        chk("post_radius", radius, 32'h40000000);
        chk("post_posX", posX, 32'h3F800000);

        // commit_req coinciding with a frame edge must wait for the next edge.
        commit_req = 1'b1; frame_clk = 1'b1;
        cycle();
        commit_req = 1'b0;
        repeat (3) cycle();
        chk("coincide_pending", 32'(pending), 32'd1);
        frame_clk = 1'b0;
        cycle();
        frame_clk = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (commit_done) done_cnt++;
            if (i == 2) frame_clk = 1'b0;
        end
        chk("done_once", 32'(done_cnt), 32'd1);

        // Write held while PENDING is accepted only once the bank reopens.
        commit_req = 1'b1;
        cycle();
        commit_req = 1'b0;
        wr_valid = 1'b1; wr_idx = 2'd2; wr_field = 2'd0; wr_data = 32'h41200000;
        repeat (5) cycle();
        frame_clk = 1'b1;
        cycle();
        frame_clk = 1'b0;
        cycle();
        cycle();
        wr_valid = 1'b0; rd_idx = 2'd2;
        cycle();
        chk("stall_old_radius", radius, 32'h0);
        commit_req = 1'b1;
        cycle();
        commit_req = 1'b0;
        cycle();
        frame_clk = 1'b1;
        cycle();
        frame_clk = 1'b0;
        cycle();
        cycle();
        chk("stall_new_radius", radius, 32'h41200000);

        // Reset mid-cycle while PENDING drops the commit.
        commit_req = 1'b1;
        cycle();
        commit_req = 1'b0;
        cycle();
        mid_reset();
        chk("rst_radius", radius, 32'h0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        frame_clk = 1'b1;
        cycle();
        chk("rst_no_done", 32'(commit_done), 32'd0);
        frame_clk = 1'b0;
        cycle();

`ifdef BODY_PARAM_STALE_CNT_EN
        mid_reset();
        repeat (3) begin
            frame_clk = 1'b1;
            cycle();
            frame_clk = 1'b0;
            cycle();
        end
        chk("stale_three", 32'(stale_frames), 32'd3);
        commit_req = 1'b1;
        cycle();
        commit_req = 1'b0;
        frame_clk = 1'b1;
        cycle();
        frame_clk = 1'b0;
        cycle();
        chk("stale_cleared", 32'(stale_frames), 32'd0);
`endif

        for (int n = 0; n < 600; n++) begin
            wr_valid   = 1'($urandom_range(0, 1));
            wr_idx     = 2'($urandom_range(0, 3));
            wr_field   = 2'($urandom_range(0, 3));
            wr_data    = $urandom();
            commit_req = ($urandom_range(0, 7) == 0);
            rd_idx     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) frame_clk = ~frame_clk;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
